// File: rtl/acb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acb_pkg
// Description : Shared sizes, state encoding and word pack/unpack helpers for
//               the word-serial front end of the acb GF(2^163) core.
//               N      - field width (operand and result bits)
//               WORD_W - stream word width
//               NWORDS - words per operand or result
// Revision    : 1.0 - initial release
// ============================================================================
package acb_pkg;

  localparam int N        = 163;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = (N + WORD_W - 1) / WORD_W;
  localparam int WCNT_W   = $clog2(2 * NWORDS);
  // The most-significant word only carries the bits above LAST_LSB.
  localparam int LAST_LSB = (NWORDS - 1) * WORD_W;
  localparam int TOP_W    = N - LAST_LSB;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Overwrite word idx of v; for the top word only the low TOP_W bits land.
  function automatic logic [N-1:0] put_word(input logic [N-1:0]      v,
                                            input logic [WCNT_W-1:0] idx,
                                            input logic [WORD_W-1:0] w);
    logic [N-1:0] r;
    r = v;
    for (int i = 0; i < NWORDS - 1; i++) begin
      if (idx == WCNT_W'(i)) r[i*WORD_W +: WORD_W] = w;
    end
    if (idx == WCNT_W'(NWORDS - 1)) r[N-1:LAST_LSB] = w[TOP_W-1:0];
    return r;
  endfunction

  // Read word idx of v, zero-extended above bit N-1; out-of-range reads 0.
  function automatic logic [WORD_W-1:0] get_word(input logic [N-1:0]      v,
                                                 input logic [WCNT_W-1:0] idx);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < NWORDS - 1; i++) begin
      if (idx == WCNT_W'(i)) r = v[i*WORD_W +: WORD_W];
    end
    if (idx == WCNT_W'(NWORDS - 1)) r[TOP_W-1:0] = v[N-1:LAST_LSB];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acb_word_port_if.sv
`default_nettype none
// ============================================================================
// Module      : acb_word_port_if
// Description : 32-bit operand-in / result-out stream bundle of acb_word_port.
//               in_valid/in_ready/in_data/in_cfg    - operand word stream
//               out_valid/out_ready/out_data/out_last - result word stream
//               master : bus side (drives operands, consumes results)
//               slave  : acb_word_port side
// Revision    : 1.0 - initial release
// ============================================================================
interface acb_word_port_if;
  import acb_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_cfg;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_cfg, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_cfg, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface
`default_nettype wire

// File: rtl/acb_word_unpack.sv
`default_nettype none
// ============================================================================
// Module      : acb_word_unpack
// Description : Result register for the acb core with a word-select mux.
//               clk, rst  - clock, asynchronous active-high reset
//               capture   - load c_in into the result register
//               c_in      - 163-bit result from the core
//               word_sel  - index of the word presented on word_out
//               word_out  - selected word, zero-extended above bit 162
//               last      - word_sel addresses the final word
// Revision    : 1.0 - initial release
// ============================================================================
module acb_word_unpack
  import acb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [N-1:0]      c_in,
  input  logic [WCNT_W-1:0] word_sel,
  output logic [WORD_W-1:0] word_out,
  output logic              last
);

  localparam logic [WCNT_W-1:0] c_last_word = WCNT_W'(NWORDS - 1);

  logic [N-1:0] r_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_c <= '0;
    else if (capture) r_c <= c_in;
  end

  assign word_out = get_word(r_c, word_sel);
  assign last     = (word_sel == c_last_word);

endmodule
`default_nettype wire

// File: rtl/acb_word_port.sv
`default_nettype none
// ============================================================================
// Module      : acb_word_port
// Description : Word-serial front end for the acb GF(2^163) core. Packs A and
//               B from 32-bit words, pulses the core start, captures C on
//               done and streams it back as 32-bit words.
//               clk, rst          - clock, asynchronous active-high reset
//               bus (slave)       - operand-in / result-out word streams
//               busy              - start or wait phase in progress
//               err               - sticky watchdog flag
//               acb_A/B/enable/configuration - operands and start to core
//               acb_C/acb_done    - result and completion from core
//               Optional macro ACB_WORD_PORT_TIMEOUT_EN adds a watchdog of
//               TIMEOUT_CYC cycles on the wait phase; without it err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module acb_word_port
    import acb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 511
)
(
    input  logic                  clk,
    input  logic                  rst,
    acb_word_port_if.slave        bus,
    output logic                  busy,
    output logic                  err,
    output logic [N-1:0]          acb_A,
    output logic [N-1:0]          acb_B,
    output logic                  acb_enable,
    output logic                  acb_configuration,
    input  logic [N-1:0]          acb_C,
    input  logic                  acb_done
);

    localparam logic [WCNT_W-1:0] c_last_in  = WCNT_W'(2 * NWORDS - 1);
    localparam logic [WCNT_W-1:0] c_last_out = WCNT_W'(NWORDS - 1);
    localparam logic [WCNT_W-1:0] c_b_base   = WCNT_W'(NWORDS);

    state_t            r_state, w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
    logic [N-1:0]      r_a, r_b;
    logic              r_cfg;
    logic              w_in_fire, w_capture, w_timeout, w_fill_b;
    logic [WCNT_W-1:0] w_word_idx;
    logic [WORD_W-1:0] w_res_word;
    logic              w_res_last;

    assign w_in_fire = (r_state == S_LOAD) && bus.in_valid;
    assign w_capture = (r_state == S_WAIT) && acb_done;

`ifdef ACB_WORD_PORT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Counts completed wait cycles; fires on the last allowed one.
    assign w_timeout = (r_state == S_WAIT) && !acb_done &&
                       (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && !acb_done && !w_timeout) r_tmo <= r_tmo + 1'b1;
            else                                                r_tmo <= '0;
            if (w_timeout)                           r_err <= 1'b1;
            else if (w_in_fire && (r_wcnt == '0))    r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (r_wcnt == c_last_in) begin
                        w_wcnt_nxt  = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_wcnt_nxt  = r_wcnt + 1'b1;
                    end
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (acb_done) begin
                    w_state_nxt = S_OUT;
                end else if (w_timeout) begin
                    w_state_nxt = S_LOAD;
                    w_wcnt_nxt  = '0;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (r_wcnt == c_last_out) begin
                        w_wcnt_nxt  = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_wcnt_nxt  = r_wcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    // Words 0..NWORDS-1 go to A, the next NWORDS to B.
    assign w_fill_b   = (r_wcnt >= c_b_base);
    assign w_word_idx = w_fill_b ? (r_wcnt - c_b_base) : r_wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cfg <= 1'b0;
        end else if (w_in_fire) begin
            if (w_fill_b) r_b <= put_word(r_b, w_word_idx, bus.in_data);
            else          r_a <= put_word(r_a, w_word_idx, bus.in_data);
            if (r_wcnt == '0) r_cfg <= bus.in_cfg;
        end
    end

    acb_word_unpack u_unpack (
        .clk      (clk),
        .rst      (rst),
        .capture  (w_capture),
        .c_in     (acb_C),
        .word_sel (r_wcnt),
        .word_out (w_res_word),
        .last     (w_res_last)
    );

    assign bus.in_ready      = (r_state == S_LOAD);
    assign bus.out_valid     = (r_state == S_OUT);
    assign bus.out_data      = (r_state == S_OUT) ? w_res_word : '0;
    assign bus.out_last      = (r_state == S_OUT) && w_res_last;
    assign busy              = (r_state == S_START) || (r_state == S_WAIT);
    assign acb_enable        = (r_state == S_START);
    assign acb_A             = r_a;
    assign acb_B             = r_b;
    assign acb_configuration = r_cfg;

endmodule
`default_nettype wire
